// File: rtl/ss_uart_tx.sv
// ss_uart_tx: memory-mapped 8N1 UART transmitter on the sim-top slave bus.
// CPU-written bytes are queued in a TX FIFO and shifted out LSB first on tx.
//
// Ports
//   clk     in   1   clock, all logic on posedge
//   resetn  in   1   asynchronous active-low reset
//   req     in   1   request, already address-qualified by the parent
//   addr    in   32  byte address, only addr[3:0] decoded
//   we      in   1   1=write, 0=read
//   be      in   4   byte enables
//   wdata   in   32  write data
//   rdata   out  32  read data, valid with rvalid
//   gnt     out  1   grant (= req)
//   rvalid  out  1   response valid, one cycle after a granted req
//   err     out  1   error response, qualified by rvalid
//   tx      out  1   serial line, idle high
//
// Register map (addr[3:0])
//   0x0 TXDATA  W: push wdata[7:0] when be[0]; R: 0
//   0x4 STATUS  R: [0] full, [1] empty, [2] busy, [15:8] FIFO level; W: error
//   0x8 BAUDDIV RW [15:0], clocks per bit, 0 behaves as 1
//   0xC and misaligned addresses: error, no side effect
//
// Build option: define UART_TX_SIM_PRINT_EN to echo every byte loaded into
// the shifter to the simulator console (simulation only, no extra ports).
//
// State | meaning
// IDLE  | line high, waiting for the FIFO to become non-empty
// START | start bit (tx=0)
// DATA  | eight data bits, LSB first (tx=shift[0])
// STOP  | stop bit (tx=1); chains straight into START if more data is queued

module ss_uart_tx #(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] BAUD_DIV_RST = 16'd4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        gnt,
  output logic        rvalid,
  output logic        err,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic [15:0]     baud_div;
  logic [15:0]     baud_cnt;
  logic [7:0]      shift;
  logic [2:0]      bit_idx;

  logic full, empty, busy;
  logic aligned, sel_tx, sel_st, sel_bd, sel_bad;
  logic push_req, push, push_drop, pop;
  logic load_cnt, shift_en, cnt_zero;
  logic bus_err;
  logic [31:0] rd_data;
  logic [15:0] div_m1;
  logic unused_bits;

  assign unused_bits = ^{addr[31:4], wdata[31:16], be[3:2]};

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign busy  = (state != IDLE);
  assign gnt   = req;

  // ---------------- bus decode ----------------
  assign aligned  = (addr[1:0] == 2'b00);
  assign sel_tx   = aligned && (addr[3:2] == 2'd0);
  assign sel_st   = aligned && (addr[3:2] == 2'd1);
  assign sel_bd   = aligned && (addr[3:2] == 2'd2);
  assign sel_bad  = !aligned || (addr[3:2] == 2'd3);

  assign push_req  = req && we && sel_tx && be[0];
  assign push      = push_req && !full;
  // A full FIFO drops the byte even if the serializer pops in the same cycle.
  assign push_drop = push_req && full;
  assign bus_err   = req && (sel_bad || (we && sel_st) || push_drop);

  always_comb begin
    rd_data = '0;
    if (req && !we) begin
      if (sel_st)
        rd_data = {16'h0, 8'(level), 5'b0, busy, empty, full};
      else if (sel_bd)
        rd_data = {16'h0, baud_div};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid   <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      baud_div <= BAUD_DIV_RST;
    end else begin
      rvalid <= req;
      err    <= bus_err;
      rdata  <= rd_data;
      if (req && we && sel_bd) begin
        if (be[0]) baud_div[7:0]  <= wdata[7:0];
        if (be[1]) baud_div[15:8] <= wdata[15:8];
      end
    end
  end

  // ---------------- TX FIFO ----------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------- serializer ----------------
  // The bit timer is reloaded from the live BAUDDIV at every bit boundary,
  // so a divider write takes effect from the next bit onward.
  assign div_m1   = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
  assign cnt_zero = (baud_cnt == 16'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_cnt  = 1'b0;
    shift_en  = 1'b0;
    tx        = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          load_cnt  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (cnt_zero) begin
          load_cnt  = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        tx = shift[0];
        if (cnt_zero) begin
          load_cnt = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt_zero) begin
          if (!empty) begin
            pop       = 1'b1;
            load_cnt  = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      baud_cnt <= '0;
      shift    <= '0;
      bit_idx  <= '0;
    end else begin
      if (load_cnt)
        baud_cnt <= div_m1;
      else if (!cnt_zero)
        baud_cnt <= baud_cnt - 16'd1;
      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_idx <= '0;
      end else if (shift_en) begin
        shift   <= {1'b0, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

`ifdef UART_TX_SIM_PRINT_EN
  always @(posedge clk) begin
    if (resetn && pop) $write("%c", mem[rd_ptr]);
  end
`else
  // No console echo in this build.
`endif

endmodule

// File: tb/tb_ss_uart_tx.sv
module tb_ss_uart_tx;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        gnt, rvalid, err, tx;

  ss_uart_tx #(.FIFO_DEPTH(16), .BAUD_DIV_RST(16'd4)) dut (
    .clk(clk), .resetn(resetn), .req(req), .addr(addr), .we(we), .be(be),
    .wdata(wdata), .rdata(rdata), .gnt(gnt), .rvalid(rvalid), .err(err), .tx(tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rsp_t;

  typedef struct packed {
    logic [7:0]      d;
    logic            nogap;
    logic [9:0][7:0] len;
  } frame_t;

  rsp_t   rsp_q[$];
  frame_t tx_q[$];
  bit     mon_busy = 1'b0;
  int     last_end = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] d, input int l, input logic ng);
    frame_t f;
    f.d     = d;
    f.nogap = ng;
    for (int i = 0; i < 10; i++) f.len[i] = 8'(l);
    return f;
  endfunction

  // Bus response monitor: each rvalid pops one expectation.
  always @(negedge clk) begin
    if (rvalid) begin
      if (rsp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL rvalid_unexpected: got rvalid=1 at cycle %0d expected no response", cyc);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("rsp_cycle", cyc, r.due);
        check("rsp_rdata", rdata, r.rdata);
        check("rsp_err", {31'b0, err}, {31'b0, r.err});
      end
    end
  end

  // Serial monitor: checks every bit of each expected frame for its exact length.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && tx === 1'b0) begin
        mon_busy = 1'b1;
        if (tx_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL tx_unexpected_frame: got start bit at cycle %0d expected idle line", cyc);
          for (int t = 0; t < 3000 && tx === 1'b0; t++) @(negedge clk);
        end else begin
          frame_t f;
          logic   aborted;
          f = tx_q.pop_front();
          if (f.nogap) check("frame_gap", cyc, last_end + 1);
          aborted = 1'b0;
          for (int b = 0; b < 10; b++) begin
            logic ok, expb;
            ok   = 1'b1;
            expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : f.d[b-1];
            for (int k = 0; k < int'(f.len[b]); k++) begin
              if (!(b == 0 && k == 0)) @(negedge clk);
              if (!resetn) begin
                aborted = 1'b1;
                break;
              end
              if (tx !== expb) ok = 1'b0;
            end
            if (aborted) break;
            check($sformatf("frame_%02h_bit%0d_ok", f.d, b), {31'b0, ok}, 32'd1);
          end
          if (!aborted) last_end = cyc;
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    req   = 1'b1;
    we    = w;
    addr  = a;
    be    = b;
    wdata = wd;
    rsp_q.push_back('{rdata: exp_rd, err: exp_err, due: cyc + 1});
    #1 check("gnt", {31'b0, gnt}, 32'd1);
    @(posedge clk);
    #1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    be    = '0;
    wdata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max);
    int t;
    t = 0;
    while ((tx_q.size() != 0 || mon_busy) && t < max) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (t >= max) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_done_timeout: got %0d frames pending expected 0", tx_q.size());
    end
    idle(3);
  endtask

  initial begin
    frame_t f;
    resetn = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_rvalid", {31'b0, rvalid}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    resetn = 1'b1;
    idle(1);

    // Status after reset: empty only.
    bus(0, 32'h4, 4'hf, 0, 32'h0000_0002, 0);

    // Error cases and register side effects.
    bus(0, 32'hC, 4'hf, 0, 0, 1);
    bus(1, 32'h4, 4'hf, 32'hffff_ffff, 0, 1);
    bus(1, 32'hC, 4'hf, 32'h1234, 0, 1);
    bus(0, 32'h9, 4'hf, 0, 0, 1);
    bus(1, 32'h1, 4'hf, 32'h41, 0, 1);
    bus(0, 32'h8, 4'hf, 0, 32'd4, 0);
    bus(1, 32'h0, 4'b1110, 32'h41, 0, 0);
    bus(0, 32'h4, 4'hf, 0, 32'h0000_0002, 0);
    bus(0, 32'h0, 4'hf, 0, 0, 0);
    // BAUDDIV byte lanes.
    bus(1, 32'h8, 4'b0010, 32'h0000_ab77, 0, 0);
    bus(0, 32'h8, 4'hf, 0, 32'h0000_ab04, 0);
    bus(1, 32'h8, 4'b0001, 32'h0000_1205, 0, 0);
    bus(0, 32'h8, 4'hf, 0, 32'h0000_ab05, 0);
    bus(1, 32'h8, 4'b0011, 32'd4, 0, 0);
    idle(5);

    // Single frame 0x55 at 4 clocks/bit; busy for exactly 40 clocks.
    tx_q.push_back(mk(8'h55, 4, 1'b0));
    bus(1, 32'h0, 4'b0001, 32'h55, 0, 0);
    bus(0, 32'h4, 4'hf, 0, 32'h0000_0100, 0);
    idle(39);
    bus(0, 32'h4, 4'hf, 0, 32'h0000_0006, 0);
    bus(0, 32'h4, 4'hf, 0, 32'h0000_0002, 0);
    wait_done(200);

    // BAUDDIV=0 behaves as 1 clock per bit.
    bus(1, 32'h8, 4'b0011, 32'd0, 0, 0);
    bus(0, 32'h8, 4'hf, 0, 32'd0, 0);
    tx_q.push_back(mk(8'h96, 1, 1'b0));
    bus(1, 32'h0, 4'b0001, 32'h96, 0, 0);
    wait_done(100);

    // Divider change 4->8 during data bit 2 of the first frame.
    bus(1, 32'h8, 4'b0011, 32'd4, 0, 0);
    f = mk(8'ha3, 8, 1'b0);
    f.len[0] = 8'd4;
    f.len[1] = 8'd4;
    f.len[2] = 8'd4;
    tx_q.push_back(f);
    tx_q.push_back(mk(8'h3c, 8, 1'b1));
    bus(1, 32'h0, 4'b0001, 32'ha3, 0, 0);
    bus(1, 32'h0, 4'b0001, 32'h3c, 0, 0);
    idle(9);
    bus(1, 32'h8, 4'b0011, 32'd8, 0, 0);
    wait_done(400);

    // Fill the FIFO: 17 accepted, the next one is dropped with err.
    bus(1, 32'h8, 4'b0011, 32'd100, 0, 0);
    bus(0, 32'h8, 4'hf, 0, 32'd100, 0);
    for (int i = 0; i < 17; i++) tx_q.push_back(mk(8'(i * 29 + 1), 100, i > 0));
    for (int i = 0; i < 17; i++) bus(1, 32'h0, 4'b0001, 32'(8'(i * 29 + 1)), 0, 0);
    bus(1, 32'h0, 4'b0001, 32'hee, 0, 1);
    bus(0, 32'h4, 4'hf, 0, 32'h0000_1005, 0);
    wait_done(18000);

    // Reset in the middle of a data bit.
    bus(1, 32'h8, 4'b0011, 32'd6, 0, 0);
    tx_q.push_back(mk(8'h00, 6, 1'b0));
    bus(1, 32'h0, 4'b0001, 32'h00, 0, 0);
    bus(1, 32'h0, 4'b0001, 32'h11, 0, 0);
    bus(1, 32'h0, 4'b0001, 32'h22, 0, 0);
    idle(17);
    check("pre_reset_tx_low", {31'b0, tx}, 32'd0);
    #2 resetn = 1'b0;
    #1 check("reset_mid_tx", {31'b0, tx}, 32'd1);
    tx_q.delete();
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    bus(0, 32'h4, 4'hf, 0, 32'h0000_0002, 0);
    bus(0, 32'h8, 4'hf, 0, 32'd4, 0);
    idle(100);

    check("rsp_q_empty", rsp_q.size(), 0);
    check("tx_q_empty", tx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
